fetch_byte_queue: RTL and testbench

//  Instruction-byte queue feeding the decoder. Fetches 64B lines over the

---
 rtl/fetch_byte_queue.sv | 191 +++++++++++++++++++
 tb/tb_fetch_byte_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: instruction-byte queue feeding the decoder.
//   Fetches 64B lines as eight 64-bit read beats into a circular byte buffer
//   and presents a WIN_BYTES-byte window at the current decode RIP. The
//   decoder retires bytes through consume. A redirect flushes the queue and
//   restarts fetch at entry.
// Ports:
//   clk, reset (async, active-low)
//   entry/redirect                 restart RIP and flush request
//   req_valid/req_addr/req_ready   line read request (req_addr[5:0]=0)
//   resp_valid/resp_data           read beats, address order, byte 0 in [7:0]
//   win_valid/win_bytes/win_rip    decode window at rd_ptr, byte i in [8i+7:8i]
//   consume                        bytes retired this cycle (0..WIN_BYTES)
//   occupancy                      valid bytes at or past rd_ptr
// Optional: define FBQ_STATS_EN to add stat_lines (lines fully received)
//   and stat_starve (cycles with win_valid=0 outside DRAIN), both saturating.
module fetch_byte_queue #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned WIN_BYTES   = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  entry,
  input  logic                         redirect,
  output logic                         req_valid,
  output logic [63:0]                  req_addr,
  input  logic                         req_ready,
  input  logic                         resp_valid,
  input  logic [63:0]                  resp_data,
  output logic                         win_valid,
  output logic [8*WIN_BYTES-1:0]       win_bytes,
  output logic [63:0]                  win_rip,
  input  logic [3:0]                   consume,
  output logic [$clog2(DEPTH_BYTES):0] occupancy
`ifdef FBQ_STATS_EN
  ,
  output logic [31:0]                  stat_lines,
  output logic [31:0]                  stat_starve
`endif
);

  localparam int unsigned IW = $clog2(DEPTH_BYTES);
  localparam int unsigned PW = IW + 1;
  localparam logic [3:0]  WIN_C = 4'(WIN_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      beats_q, beats_d;
  logic [63:0]     line_d;
  logic [PW-1:0]   wr_ptr, wr_d, rd_ptr, rd_d;
  logic [63:0]     rip_d;
  logic [2:0]      skip_q, skip_d;   // leading quadwords of the first line to drop
  logic            beat_wr_c;
  logic            line_done_c;
  logic            consume_ok_c;
  logic [2:0]      beat_idx_c;
  logic [3:0]      outstanding_c;
  logic [PW-1:0]   occ_raw_c;
  logic [7:0]      mem [DEPTH_BYTES];

  assign beat_idx_c    = 3'(4'd8 - beats_q);
  assign outstanding_c = beats_q - 4'(resp_valid);

  // Right after a misaligned redirect rd_ptr sits ahead of wr_ptr; report 0 then.
  assign occ_raw_c = wr_ptr - rd_ptr;
  assign occupancy = (occ_raw_c > PW'(DEPTH_BYTES)) ? '0 : occ_raw_c;
  assign win_valid = (occupancy >= PW'(WIN_BYTES));
  assign consume_ok_c = win_valid && (consume != 4'd0) && (consume <= WIN_C);

  // Next-state, pointer and fetch-address logic
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    line_d      = req_addr;
    wr_d        = wr_ptr;
    rd_d        = rd_ptr;
    rip_d       = win_rip;
    skip_d      = skip_q;
    beat_wr_c   = 1'b0;
    line_done_c = 1'b0;
    if (redirect) begin
      wr_d   = '0;
      rd_d   = PW'(entry[2:0]);
      rip_d  = entry;
      line_d = {entry[63:6], 6'b0};
      skip_d = entry[5:3];
      unique case (state_q)
        RESP, DRAIN: begin
          beats_d = outstanding_c;
          state_d = (outstanding_c != 4'd0) ? DRAIN : IDLE;
        end
        REQ: begin
          beats_d = 4'd8;
          state_d = req_ready ? DRAIN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (consume_ok_c) begin
        rd_d  = rd_ptr + PW'(consume);
        rip_d = win_rip + 64'(consume);
      end
      unique case (state_q)
        IDLE: if (occupancy <= PW'(DEPTH_BYTES - 64)) state_d = REQ;
        REQ: if (req_ready) begin
          state_d = RESP;
          beats_d = 4'd8;
        end
        RESP: if (resp_valid) begin
          beats_d = beats_q - 4'd1;
          if (beat_idx_c >= skip_q) begin
            beat_wr_c = 1'b1;
            wr_d      = wr_ptr + PW'(8);
          end
          if (beats_q == 4'd1) begin
            state_d     = IDLE;
            line_done_c = 1'b1;
          end
        end
        DRAIN: begin
          if (resp_valid) beats_d = beats_q - 4'd1;
          if (beats_q == 4'd0 || (resp_valid && beats_q == 4'd1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (line_done_c) begin
        line_d = req_addr + 64'd64;
        skip_d = '0;
      end
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beats_q   <= '0;
      req_addr  <= '0;
      req_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      win_rip   <= '0;
      skip_q    <= '0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      req_addr  <= line_d;
      req_valid <= (state_d == REQ);
      wr_ptr    <= wr_d;
      rd_ptr    <= rd_d;
      win_rip   <= rip_d;
      skip_q    <= skip_d;
    end
  end

  // Byte buffer: wr_ptr is always quadword aligned, so a beat never straddles
  always_ff @(posedge clk) begin
    if (beat_wr_c) begin
      for (int k = 0; k < 8; k++) begin
        mem[wr_ptr[IW-1:0] + IW'(k)] <= resp_data[8*k +: 8];
      end
    end
  end

  // Decode window, wrapping around the buffer end
  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < int'(WIN_BYTES); i++) begin
      win_bytes[8*i +: 8] = mem[rd_ptr[IW-1:0] + IW'(i)];
    end
  end

`ifdef FBQ_STATS_EN
  // Saturating statistics, untouched by redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lines  <= '0;
      stat_starve <= '0;
    end else begin
      if (line_done_c && stat_lines != '1) stat_lines <= stat_lines + 32'd1;
      if (!win_valid && state_q != DRAIN && stat_starve != '1)
        stat_starve <= stat_starve + 32'd1;
    end
  end
`endif

  // Decoder must only retire bytes that are in a valid window
  a_consume_legal: assert property (@(posedge clk) disable iff (!reset)
    (!redirect && consume != 4'd0) |-> (win_valid && consume <= WIN_C));

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue: reset, aligned/misaligned redirect,
// same-cycle beat+consume, redirect mid-burst, and streaming with wrap.
module tb_fetch_byte_queue;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned WIN   = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  entry;
  logic         redirect;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_ready;
  logic         resp_valid;
  logic [63:0]  resp_data;
  logic         win_valid;
  logic [8*WIN-1:0] win_bytes;
  logic [63:0]  win_rip;
  logic [3:0]   consume;
  logic [7:0]   occupancy;
`ifdef FBQ_STATS_EN
  logic [31:0]  stat_lines;
  logic [31:0]  stat_starve;
  int           exp_starve = 0;
`endif
  logic         tb_drain = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_byte_queue #(.DEPTH_BYTES(DEPTH), .WIN_BYTES(WIN)) dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect(redirect),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .win_valid(win_valid), .win_bytes(win_bytes), .win_rip(win_rip),
    .consume(consume), .occupancy(occupancy)
`ifdef FBQ_STATS_EN
    , .stat_lines(stat_lines), .stat_starve(stat_starve)
`endif
  );

`ifdef FBQ_STATS_EN
  // Each negedge sees the window state that the next posedge samples
  always @(negedge clk) if (reset && !win_valid && !tb_drain) exp_starve++;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image seen on the bus
  function automatic logic [7:0] mb(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mb(a + 64'(k));
    return r;
  endfunction

  function automatic logic [8*WIN-1:0] exp_win(input logic [63:0] rip);
    logic [8*WIN-1:0] r;
    for (int i = 0; i < int'(WIN); i++) r[8*i +: 8] = mb(rip + 64'(i));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [63:0] exp_addr, input string tag);
    int n;
    n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_valid"}, 128'(req_valid), 128'(1));
    check({tag, "_req_addr"}, 128'(req_addr), 128'(exp_addr));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] line, input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      resp_valid = 1'b1;
      resp_data  = beat(line + 64'(8 * b));
      tick();
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bl;
    int bidx;
    int lines;
    int cyc;
    int cons;
    int exp_occ;
    logic [63:0] cur_line;
    logic [63:0] exp_line;
    logic [63:0] exp_rip;

    reset = 1'b0; entry = '0; redirect = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; consume = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 128'(req_valid), 128'(0));
    check("rst_req_addr", 128'(req_addr), 128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_win_valid", 128'(win_valid), 128'(0));
    check("rst_win_rip", 128'(win_rip), 128'(0));
`ifdef FBQ_STATS_EN
    check("rst_stat_lines", 128'(stat_lines), 128'(0));
    check("rst_stat_starve", 128'(stat_starve), 128'(0));
`endif
    reset = 1'b1;

    // Aligned redirect and one full line
    redirect = 1'b1; entry = 64'h1000;
    tick();
    redirect = 1'b0;
    check("t1_addr_next", 128'(req_addr), 128'(64'h1000));
    check("t1_valid_next", 128'(req_valid), 128'(0));
    wait_req(64'h1000, "t1");
    send_beats(64'h1000, 0, 1);
    check("t1_occ_beat0", 128'(occupancy), 128'(8));
    send_beats(64'h1000, 1, 7);
    check("t1_occ", 128'(occupancy), 128'(64));
    check("t1_win_valid", 128'(win_valid), 128'(1));
    check("t1_rip", 128'(win_rip), 128'(64'h1000));
    check("t1_win", 128'(win_bytes), 128'(exp_win(64'h1000)));

    // Misaligned redirect: leading quadwords dropped, rd_ptr inside first quadword
    redirect = 1'b1; entry = 64'h1013;
    tick();
    redirect = 1'b0;
    check("t2_occ_flush", 128'(occupancy), 128'(0));
    wait_req(64'h1000, "t2");
    send_beats(64'h1000, 0, 2);
    check("t2_occ_dropped", 128'(occupancy), 128'(0));
    send_beats(64'h1000, 2, 6);
    check("t2_occ", 128'(occupancy), 128'(45));
    check("t2_rip", 128'(win_rip), 128'(64'h1013));
    check("t2_win", 128'(win_bytes), 128'(exp_win(64'h1013)));

    // Beat write and consume in the same cycle
    redirect = 1'b1; entry = 64'h2000;
    tick();
    redirect = 1'b0;
    wait_req(64'h2000, "t3");
    send_beats(64'h2000, 0, 3);
    check("t3_occ24", 128'(occupancy), 128'(24));
    consume = 4'd4;
    tick();
    consume = 4'd0;
    check("t3_occ20", 128'(occupancy), 128'(20));
    resp_valid = 1'b1; resp_data = beat(64'h2018); consume = 4'd7;
    tick();
    resp_valid = 1'b0; consume = 4'd0;
    check("t3_occ21", 128'(occupancy), 128'(21));
    check("t3_rip", 128'(win_rip), 128'(64'h200B));
    check("t3_win", 128'(win_bytes), 128'(exp_win(64'h200B)));
    send_beats(64'h2000, 4, 4);
    check("t3_occ53", 128'(occupancy), 128'(53));

    // Redirect on beat 3 of the next line: remaining beats drained
    wait_req(64'h2040, "t4");
    send_beats(64'h2040, 0, 3);
    check("t4_occ77", 128'(occupancy), 128'(77));
    redirect = 1'b1; entry = 64'h3000;
    resp_valid = 1'b1; resp_data = beat(64'h2058);
    tick();
    redirect = 1'b0; resp_valid = 1'b0;
    tb_drain = 1'b1;
    check("t4_occ_flush", 128'(occupancy), 128'(0));
    check("t4_rip", 128'(win_rip), 128'(64'h3000));
    for (int b = 4; b < 8; b++) begin
      resp_valid = 1'b1; resp_data = beat(64'h2040 + 64'(8 * b));
      tick();
      check("t4_drain_occ", 128'(occupancy), 128'(0));
      check("t4_drain_noreq", 128'(req_valid), 128'(0));
    end
    resp_valid = 1'b0;
    tb_drain = 1'b0;
`ifdef FBQ_STATS_EN
    check("t4_stat_lines", 128'(stat_lines), 128'(3));
`endif
    wait_req(64'h3000, "t4_new");

    // Streaming with consume=15 whenever possible; pointers wrap
    bl = 8; bidx = 0; lines = 0; cyc = 0; exp_occ = 0;
    cur_line = 64'h3000; exp_line = 64'h3040; exp_rip = 64'h3000;
    while (!(lines == 4 && bl == 0) && cyc < 300) begin
      resp_valid = 1'b0; req_ready = 1'b0; cons = 0;
      if (bl > 0) begin
        resp_valid = 1'b1;
        resp_data  = beat(cur_line + 64'(8 * bidx));
        bidx++; bl--;
        if (bl == 0) lines++;
      end else if (req_valid) begin
        check("t5_req_addr", 128'(req_addr), 128'(exp_line));
        check("t5_req_free", 128'(occupancy <= 8'd64), 128'(1));
        req_ready = 1'b1;
        cur_line = exp_line; exp_line = exp_line + 64'd64;
        bl = 8; bidx = 0;
      end
      if (win_valid) begin
        check("t5_win", 128'(win_bytes), 128'(exp_win(exp_rip)));
        cons = 15;
      end
      consume = 4'(cons);
      tick();
      if (resp_valid) exp_occ += 8;
      exp_occ -= cons;
      exp_rip = exp_rip + 64'(cons);
      cyc++;
    end
    resp_valid = 1'b0; req_ready = 1'b0; consume = 4'd0;
    check("t5_done", 128'(lines == 4 && bl == 0), 128'(1));
    check("t5_rip", 128'(win_rip), 128'(exp_rip));
    check("t5_occ", 128'(occupancy), 128'(exp_occ));
    check("t5_wrapped", 128'(exp_rip - 64'h3000 > 64'd128), 128'(1));
`ifdef FBQ_STATS_EN
    check("t5_stat_lines", 128'(stat_lines), 128'(7));
    check("t5_stat_starve", 128'(stat_starve), 128'(exp_starve));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
